// File: rtl/multicycle_seq.sv
// Multicycle control sequencer for a MIPS-subset datapath (LW, SW, ADDI, six R-type ALU ops).
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a sticky HALT on unsupported encodings.
module multicycle_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] CLS_R    = 2'd0;
  localparam logic [1:0] CLS_LW   = 2'd1;
  localparam logic [1:0] CLS_SW   = 2'd2;
  localparam logic [1:0] CLS_ADDI = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic [1:0]  cls_reg;
  logic [1:0]  cls_dec;
  logic [5:0]  funct_reg;
  logic        illegal_reg;
  logic [15:0] count_reg;
  logic        legal;
  logic        retire;

  // Only opcode and funct fields matter to control; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  // Instruction classification, consumed only while in DECODE.
  always_comb begin
    legal   = 1'b0;
    cls_dec = CLS_R;
    case (instr[31:26])
      OP_LW: begin
        legal   = 1'b1;
        cls_dec = CLS_LW;
      end
      OP_SW: begin
        legal   = 1'b1;
        cls_dec = CLS_SW;
      end
      OP_ADDI: begin
        legal   = 1'b1;
        cls_dec = CLS_ADDI;
      end
      OP_RTYPE: begin
        cls_dec = CLS_R;
        case (instr[5:0])
          6'b100000, 6'b100010, 6'b100100,
          6'b100101, 6'b100111, 6'b100110: legal = 1'b1;
          default:                         legal = 1'b0;
        endcase
      end
      default: begin
        legal   = 1'b0;
        cls_dec = CLS_R;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC:   state_next = (cls_reg == CLS_LW || cls_reg == CLS_SW) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_next = (cls_reg == CLS_LW) ? S_WB : S_FETCH;
        end else begin
          state_next = S_MEM;
        end
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Class and funct are captured once so later changes on instr cannot disturb execution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_reg     <= CLS_R;
      funct_reg   <= 6'd0;
      illegal_reg <= 1'b0;
    end else if (state_reg == S_DECODE) begin
      if (legal) begin
        cls_reg   <= cls_dec;
        funct_reg <= instr[5:0];
      end else begin
        illegal_reg <= 1'b1;
      end
    end
  end

  assign retire = (state_reg == S_WB) ||
                  (state_reg == S_MEM && cls_reg == CLS_SW && dmem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 16'd0;
    end else if (retire) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // Outputs are gated by rst_n so that nothing is requested while reset is held.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 6'd0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
          pc_write = imem_ack;
        end
        S_EXEC: begin
          alu_op  = (cls_reg == CLS_R) ? funct_reg : FN_ADD;
          alu_src = (cls_reg != CLS_R);
        end
        S_MEM: begin
          alu_op    = (cls_reg == CLS_R) ? funct_reg : FN_ADD;
          alu_src   = (cls_reg != CLS_R);
          mem_read  = (cls_reg == CLS_LW);
          mem_write = (cls_reg == CLS_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (cls_reg == CLS_R);
          mem_to_reg = (cls_reg == CLS_LW);
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign retired = count_reg;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: inputs change on the falling edge, outputs checked 1 ns later.
// Covers ADD, delayed LW, SW, instruction stability, counter wrap, async reset and illegal encodings.
module tb_multicycle_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  alu_op;
  logic [2:0]  state;
  logic        illegal;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;
  int mr_cnt;

  multicycle_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_op     (alu_op),
    .state      (state),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    instr    = 32'd0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    // Reset state
    cyc(); #1;
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal", illegal, 0);
    cyc(); rst_n = 1'b1; #1;
    chk("rel_imem_req", imem_req, 1);
    cyc(); #1;
    chk("idle_state", state, 0);
    chk("idle_imem_req", imem_req, 1);
    chk("idle_ir_write", ir_write, 0);

    // ADD $t0,$t1,$t2 with immediate acks
    cyc(); instr = 32'h012A4020; imem_ack = 1'b1; #1;
    chk("add_ir_write", ir_write, 1);
    chk("add_pc_write", pc_write, 1);
    cyc(); imem_ack = 1'b0; #1;
    chk("add_decode", state, 1);
    chk("add_dec_imem_req", imem_req, 0);
    cyc(); #1;
    chk("add_exec", state, 2);
    chk("add_alu_op", alu_op, 6'b100000);
    chk("add_alu_src", alu_src, 0);
    chk("add_exec_reg_write", reg_write, 0);
    cyc(); #1;
    chk("add_wb", state, 4);
    chk("add_reg_write", reg_write, 1);
    chk("add_reg_dst", reg_dst, 1);
    chk("add_mem_to_reg", mem_to_reg, 0);
    cyc(); #1;
    chk("add_done_state", state, 0);
    chk("add_retired", retired, 1);
    $display("TXN ADD  instr=012a4020 state=%0d retired=%0d", state, retired);

    // LW with dmem_ack arriving in the fourth MEM cycle
    cyc(); instr = 32'h8D090004; imem_ack = 1'b1; #1;
    chk("lw_fetch", state, 0);
    cyc(); imem_ack = 1'b0; #1;
    chk("lw_decode", state, 1);
    cyc(); #1;
    chk("lw_exec", state, 2);
    chk("lw_alu_op", alu_op, 6'b100000);
    chk("lw_alu_src", alu_src, 1);
    mr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); dmem_ack = (i == 3); #1;
      chk("lw_mem_state", state, 3);
      chk("lw_mem_write", mem_write, 0);
      chk("lw_mem_alu_src", alu_src, 1);
      if (mem_read) mr_cnt++;
    end
    chk("lw_mem_read_cycles", mr_cnt, 4);
    cyc(); dmem_ack = 1'b0; #1;
    chk("lw_wb", state, 4);
    chk("lw_mem_to_reg", mem_to_reg, 1);
    chk("lw_reg_dst", reg_dst, 0);
    chk("lw_reg_write", reg_write, 1);
    chk("lw_wb_mem_read", mem_read, 0);
    cyc(); #1;
    chk("lw_done_state", state, 0);
    chk("lw_retired", retired, 2);
    $display("TXN LW   instr=8d090004 state=%0d retired=%0d", state, retired);

    // Preload the retire counter just below wrap, then ADDI with instr toggled mid-EXEC
    cyc();
    force dut.count_reg = 16'hFFFF;
    #1 release dut.count_reg;
    #1;
    chk("wrap_preload", retired, 16'hFFFF);
    cyc(); instr = 32'h21080001; imem_ack = 1'b1; #1;
    chk("addi_ir_write", ir_write, 1);
    cyc(); imem_ack = 1'b0; #1;
    chk("addi_decode", state, 1);
    cyc(); #1;
    chk("addi_exec", state, 2);
    chk("addi_alu_op", alu_op, 6'b100000);
    instr = 32'h012A4022; #1;
    chk("addi_alu_op_stable", alu_op, 6'b100000);
    chk("addi_alu_src_stable", alu_src, 1);
    cyc(); #1;
    chk("addi_wb", state, 4);
    chk("addi_reg_dst", reg_dst, 0);
    chk("addi_mem_to_reg", mem_to_reg, 0);
    chk("addi_reg_write", reg_write, 1);
    cyc(); #1;
    chk("addi_done_state", state, 0);
    chk("wrap_retired", retired, 0);
    $display("TXN ADDI instr=21080001 state=%0d retired=%0d", state, retired);

    // SW with stray acks outside their owning states
    cyc(); instr = 32'hAD090004; imem_ack = 1'b1; #1;
    chk("sw_ir_write", ir_write, 1);
    cyc(); imem_ack = 1'b0; dmem_ack = 1'b1; #1;
    chk("sw_decode", state, 1);
    cyc(); imem_ack = 1'b1; #1;
    chk("sw_exec", state, 2);
    chk("sw_exec_ir_write", ir_write, 0);
    chk("sw_exec_mem_write", mem_write, 0);
    cyc(); imem_ack = 1'b0; #1;
    chk("sw_mem", state, 3);
    chk("sw_mem_write", mem_write, 1);
    chk("sw_mem_read", mem_read, 0);
    chk("sw_reg_write", reg_write, 0);
    cyc(); dmem_ack = 1'b0; #1;
    chk("sw_done_state", state, 0);
    chk("sw_retired", retired, 1);
    chk("sw_after_mem_write", mem_write, 0);
    $display("TXN SW   instr=ad090004 state=%0d retired=%0d", state, retired);

    // SUB with instr toggled during EXEC: latched funct must survive
    cyc(); instr = 32'h012A4022; imem_ack = 1'b1; #1;
    cyc(); imem_ack = 1'b0; #1;
    chk("sub_decode", state, 1);
    cyc(); #1;
    chk("sub_alu_op", alu_op, 6'b100010);
    instr = 32'h012A4024; #1;
    chk("sub_alu_op_stable", alu_op, 6'b100010);
    cyc(); #1;
    chk("sub_wb", state, 4);
    chk("sub_reg_dst", reg_dst, 1);
    cyc(); #1;
    chk("sub_retired", retired, 2);
    $display("TXN SUB  instr=012a4022 state=%0d retired=%0d", state, retired);

    // Asynchronous reset while LW waits in MEM
    cyc(); instr = 32'h8D090004; imem_ack = 1'b1;
    cyc(); imem_ack = 1'b0;
    cyc();
    cyc(); #1;
    chk("ar_mem_state", state, 3);
    chk("ar_mem_read_before", mem_read, 1);
    #2 rst_n = 1'b0; #1;
    chk("ar_mem_read", mem_read, 0);
    chk("ar_state", state, 0);
    chk("ar_retired", retired, 0);
    chk("ar_imem_req", imem_req, 0);
    cyc(); rst_n = 1'b1; #1;
    chk("ar_release_imem_req", imem_req, 1);
    $display("TXN ARST during MEM state=%0d retired=%0d", state, retired);

    // Illegal opcode 000010 (J)
    cyc(); instr = 32'h08000000; imem_ack = 1'b1; #1;
    cyc(); imem_ack = 1'b0; #1;
    chk("ill_j_decode", state, 1);
    cyc(); #1;
    chk("ill_j_halt", state, 5);
    chk("ill_j_flag", illegal, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); imem_ack = ~imem_ack; #1;
      chk("ill_j_hold", state, 5);
      chk("ill_j_ir_write", ir_write, 0);
      chk("ill_j_imem_req", imem_req, 0);
    end
    chk("ill_j_retired", retired, 0);
    cyc(); imem_ack = 1'b0; rst_n = 1'b0; #1;
    chk("ill_j_rst_flag", illegal, 0);
    chk("ill_j_rst_state", state, 0);
    cyc(); rst_n = 1'b1; #1;
    $display("TXN ILL  instr=08000000 recovered state=%0d", state);

    // Illegal R-type funct 101010 (SLT)
    cyc(); instr = 32'h012A402A; imem_ack = 1'b1; #1;
    cyc(); imem_ack = 1'b0; #1;
    cyc(); #1;
    chk("ill_r_halt", state, 5);
    chk("ill_r_flag", illegal, 1);
    cyc(); imem_ack = 1'b1; #1;
    chk("ill_r_hold", state, 5);
    chk("ill_r_pc_write", pc_write, 0);
    cyc(); imem_ack = 1'b0; rst_n = 1'b0; #1;
    chk("ill_r_rst_flag", illegal, 0);
    cyc(); rst_n = 1'b1; #1;
    chk("ill_r_recover", state, 0);
    $display("TXN ILL  instr=012a402a recovered state=%0d", state);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
